bypass_net: RTL and testbench

- Parametrised operand-forwarding and load-use hazard unit between the decode stage (ID) and the execute stage (EX).
- For each of NUM_RPORTS register read ports, it compares the read address against NUM_STAGES downstream write-back sources.
  - The youngest matching source's data is selected.
  - A load-use stall is requested when the matching source's data is not yet available.
- The forward select and data are registered into EX under the standard stall vector.
- A saturating stall-cycle counter is provided for performance monitoring.

---
 rtl/bypass_net.sv | 123 ++++++++++++
 tb/tb_bypass_net.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_net.sv
`default_nettype none
// ============================================================================
// Module      : bypass_net
// Description : Operand-forwarding and load-use hazard unit sitting between
//               ID and EX. Each read port picks the youngest matching
//               write-back source. A combinational stall is requested when
//               that winning source's data is still in flight. The forward
//               decision is registered into EX under the pipeline stall
//               vector. A saturating counter tracks load-use stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bypass_net #(
    parameter int NUM_RPORTS = 2,
    parameter int NUM_STAGES = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STALL_W    = 8,
    parameter int ID_BIT     = 3,
    parameter int EX_BIT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [STALL_W-1:0]             stall,
    input  logic [NUM_RPORTS-1:0]          rport_en,
    input  logic [NUM_RPORTS*ADDR_W-1:0]   rport_addr,
    input  logic [NUM_STAGES-1:0]          stg_we,
    input  logic [NUM_STAGES*ADDR_W-1:0]   stg_waddr,
    input  logic [NUM_STAGES*DATA_W-1:0]   stg_wdata,
    input  logic [NUM_STAGES-1:0]          stg_pending,
    output logic                           stallreq_for_load,
    output logic [NUM_RPORTS-1:0]          fwd_sel_r,
    output logic [NUM_RPORTS*DATA_W-1:0]   fwd_data_r,
    output logic [CNT_W-1:0]               stall_cnt
);

    // Combinational forward decision per port (next-state of the EX registers)
    logic [NUM_RPORTS-1:0]        fwd_sel_d;
    logic [NUM_RPORTS*DATA_W-1:0] fwd_data_d;
    logic [NUM_RPORTS-1:0]        port_hit_pend;

    // Registered state
    logic [NUM_RPORTS-1:0]        fwd_sel_q;
    logic [NUM_RPORTS*DATA_W-1:0] fwd_data_q;
    logic [CNT_W-1:0]             stall_cnt_q;

    // Only the ID and EX bits of the stall vector matter to this block
    logic                         unused_stall;
    assign unused_stall = ^stall;

    generate
        for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
            logic [ADDR_W-1:0]     raddr;
            logic [NUM_STAGES-1:0] match;
            logic                  sel_d;
            logic [DATA_W-1:0]     data_d;
            logic                  hit_pend;

            assign raddr = rport_addr[p*ADDR_W +: ADDR_W];

            for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
                // Register 0 is hard-wired zero and never forwards
                assign match[s] = rport_en[p] & stg_we[s]
                                & (stg_waddr[s*ADDR_W +: ADDR_W] == raddr)
                                & (raddr != '0);
            end

            // Priority pick: scan oldest to youngest so the youngest match wins
            always_comb begin
                sel_d    = 1'b0;
                data_d   = '0;
                hit_pend = 1'b0;
                for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                    if (match[s]) begin
                        sel_d    = 1'b1;
                        data_d   = stg_wdata[s*DATA_W +: DATA_W];
                        hit_pend = stg_pending[s];
                    end
                end
            end

            assign fwd_sel_d[p]                    = sel_d;
            assign fwd_data_d[p*DATA_W +: DATA_W]  = data_d;
            assign port_hit_pend[p]                = hit_pend;
        end
    endgenerate

    // A shadowed pending source never reaches port_hit_pend, so it cannot stall
    assign stallreq_for_load = |port_hit_pend;

    // EX-side forward registers: reset, flush, bubble, load, else hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_sel_q  <= '0;
            fwd_data_q <= '0;
        end else if (flush) begin
            fwd_sel_q  <= '0;
            fwd_data_q <= '0;
        end else if (stall[ID_BIT] && !stall[EX_BIT]) begin
            fwd_sel_q  <= '0;
            fwd_data_q <= '0;
        end else if (!stall[ID_BIT]) begin
            fwd_sel_q  <= fwd_sel_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Saturating load-use stall counter; deliberately unaffected by flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stallreq_for_load && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign fwd_sel_r  = fwd_sel_q;
    assign fwd_data_r = fwd_data_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bypass_net.sv
`default_nettype none
// ============================================================================
// Module      : tb_bypass_net
// Description : Scenario-driven bench for bypass_net. Expected register
//               contents are queued when stimulus is applied and compared
//               after the clock edge that should produce them. A second
//               instance with a 4-bit counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bypass_net;

    localparam int NP = 2;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [7:0]        stall;
    logic [NP-1:0]     rport_en;
    logic [NP*AW-1:0]  rport_addr;
    logic [NS-1:0]     stg_we;
    logic [NS*AW-1:0]  stg_waddr;
    logic [NS*DW-1:0]  stg_wdata;
    logic [NS-1:0]     stg_pending;

    logic              stallreq;
    logic [NP-1:0]     fwd_sel_r;
    logic [NP*DW-1:0]  fwd_data_r;
    logic [15:0]       stall_cnt;

    logic              sat_stallreq;
    logic [NP-1:0]     sat_sel;
    logic [NP*DW-1:0]  sat_data;
    logic [3:0]        sat_cnt;

    typedef struct packed {
        logic [NP-1:0]    sel;
        logic [NP*DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bypass_net u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .stall             (stall),
        .rport_en          (rport_en),
        .rport_addr        (rport_addr),
        .stg_we            (stg_we),
        .stg_waddr         (stg_waddr),
        .stg_wdata         (stg_wdata),
        .stg_pending       (stg_pending),
        .stallreq_for_load (stallreq),
        .fwd_sel_r         (fwd_sel_r),
        .fwd_data_r        (fwd_data_r),
        .stall_cnt         (stall_cnt)
    );

    bypass_net #(.CNT_W(4)) u_sat (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .stall             (stall),
        .rport_en          (rport_en),
        .rport_addr        (rport_addr),
        .stg_we            (stg_we),
        .stg_waddr         (stg_waddr),
        .stg_wdata         (stg_wdata),
        .stg_pending       (stg_pending),
        .stallreq_for_load (sat_stallreq),
        .fwd_sel_r         (sat_sel),
        .fwd_data_r        (sat_data),
        .stall_cnt         (sat_cnt)
    );

    task automatic clear_inputs();
        flush       = 1'b0;
        stall       = '0;
        rport_en    = '0;
        rport_addr  = '0;
        stg_we      = '0;
        stg_waddr   = '0;
        stg_wdata   = '0;
        stg_pending = '0;
    endtask

    task automatic set_port(input int p, input logic en, input logic [AW-1:0] a);
        rport_en[p]          = en;
        rport_addr[p*AW +: AW] = a;
    endtask

    task automatic set_src(input int s, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic pend);
        stg_we[s]              = we;
        stg_waddr[s*AW +: AW]  = a;
        stg_wdata[s*DW +: DW]  = d;
        stg_pending[s]         = pend;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [NP-1:0] sel, input logic [NP*DW-1:0] data);
        exp_t x;
        x.sel  = sel;
        x.data = data;
        sb_q.push_back(x);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        set_port(0, 1'b1, 5'd5);
        set_src(0, 1'b1, 5'd5, 32'h1234, 1'b1);
        tick();
        push_exp('0, '0);
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL reset_regs: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL reset_regs: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        n_checks++;
        if (sat_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
    endtask

    task automatic test_youngest();
        rst_n = 1'b1;
        clear_inputs();
        set_port(0, 1'b1, 5'd5);
        set_src(0, 1'b1, 5'd5, 32'h11, 1'b0);
        set_src(2, 1'b1, 5'd5, 32'h22, 1'b0);
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL youngest_stall: got %b want 0", stallreq); end
        push_exp(2'b01, {32'h0, 32'h11});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL youngest: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL youngest: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_port(1, 1'b1, 5'd9);
        set_src(0, 1'b1, 5'd9, 32'hDEAD, 1'b1);
        #1;
        n_checks++;
        if (stallreq !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stallreq); end
        stall[3] = 1'b1;
        stall[4] = 1'b0;
        push_exp('0, '0);
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL load_use_bubble: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL load_use_bubble: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
        set_src(0, 1'b1, 5'd9, 32'hABCD, 1'b0);
        stall = '0;
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b want 0", stallreq); end
        push_exp(2'b10, {32'hABCD, 32'h0});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL load_use_fwd: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL load_use_fwd: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
    endtask

    task automatic test_reg0_disabled();
        clear_inputs();
        set_port(0, 1'b1, 5'd0);
        set_port(1, 1'b0, 5'd7);
        set_src(0, 1'b1, 5'd0, 32'h5A, 1'b1);
        set_src(1, 1'b1, 5'd7, 32'h7B, 1'b1);
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reg0_stall: got %b want 0", stallreq); end
        push_exp(2'b00, '0);
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL reg0_disabled: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL reg0_disabled: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
    endtask

    task automatic test_shadowed();
        clear_inputs();
        set_port(0, 1'b1, 5'd9);
        set_src(0, 1'b1, 5'd9, 32'h3, 1'b0);
        set_src(1, 1'b1, 5'd9, 32'h77, 1'b1);
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL shadowed_stall: got %b want 0", stallreq); end
        push_exp(2'b01, {32'h0, 32'h3});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL shadowed_fwd: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL shadowed_fwd: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
        // Oldest-stage pending source stalls; ID and EX both held meanwhile
        clear_inputs();
        set_port(1, 1'b1, 5'd12);
        set_src(3, 1'b1, 5'd12, 32'hC0DE, 1'b1);
        stall[3] = 1'b1;
        stall[4] = 1'b1;
        #1;
        n_checks++;
        if (stallreq !== 1'b1) begin n_fail++; $display("FAIL oldest_pending: got %b want 1", stallreq); end
        push_exp(2'b01, {32'h0, 32'h3});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL oldest_hold: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL oldest_hold: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL oldest_cnt: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_hold_flush();
        clear_inputs();
        set_port(0, 1'b1, 5'd4);
        set_src(1, 1'b1, 5'd4, 32'h55, 1'b0);
        push_exp(2'b01, {32'h0, 32'h55});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL hold_load: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL hold_load: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
        stall[3] = 1'b1;
        stall[4] = 1'b1;
        set_src(1, 1'b1, 5'd4, 32'h99, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_exp(2'b01, {32'h0, 32'h55});
            tick();
            n_checks++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL hold_%0d: scoreboard empty", i); end
            else begin
                e = sb_q.pop_front();
                if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                    n_fail++;
                    $display("FAIL hold_%0d: got sel=%b data=%h want sel=%b data=%h", i, fwd_sel_r, fwd_data_r, e.sel, e.data);
                end
            end
        end
        // Flush beats the hold, and the pending match still counts
        flush = 1'b1;
        set_src(1, 1'b1, 5'd4, 32'h99, 1'b1);
        push_exp('0, '0);
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL flush: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL flush: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL flush_cnt: got %0d want 3", stall_cnt); end
        flush = 1'b0;
        stall = '0;
        set_src(1, 1'b1, 5'd4, 32'h99, 1'b0);
        push_exp(2'b01, {32'h0, 32'h99});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL reload: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL reload: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
        // Reset while stalled with a pending hazard
        rst_n = 1'b0;
        stall[3] = 1'b1;
        stall[4] = 1'b1;
        set_src(1, 1'b1, 5'd4, 32'h99, 1'b1);
        push_exp('0, '0);
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin n_fail++; $display("FAIL reset_mid: scoreboard empty"); end
        else begin
            e = sb_q.pop_front();
            if (fwd_sel_r !== e.sel || fwd_data_r !== e.data) begin
                n_fail++;
                $display("FAIL reset_mid: got sel=%b data=%h want sel=%b data=%h", fwd_sel_r, fwd_data_r, e.sel, e.data);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_mid_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_saturation();
        int exp_sat;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_sat = (i + 1 > 15) ? 15 : i + 1;
            n_checks++;
            if (sat_cnt !== exp_sat[3:0]) begin
                n_fail++;
                $display("FAIL sat_cnt_%0d: got %0d want %0d", i, sat_cnt, exp_sat);
            end
            n_checks++;
            if (stall_cnt !== 16'(i + 1)) begin
                n_fail++;
                $display("FAIL wide_cnt_%0d: got %0d want %0d", i, stall_cnt, i + 1);
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_youngest();
        test_load_use();
        test_reg0_disabled();
        test_shadowed();
        test_hold_flush();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
